// File: rtl/axil_gpio_pkg.sv
// Shared constants and helpers for the AXI4-Lite GPIO block: response codes,
// bank word count and register-bank base indices.
package axil_gpio_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DATA_BASE = 0;

  function automatic int calc_nw(input int n_gpio);
    return (n_gpio + 31) / 32;
  endfunction

  function automatic int dir_base(input int nw);
    return DATA_BASE + nw;
  endfunction

endpackage

// File: rtl/axil_gpio_sync.sv
// N-bit two-flop synchronizer for the GPIO input path (reset value 0).
module axil_gpio_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // two-stage capture of asynchronous pin levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/axil_gpio.sv
// AXI4-Lite slave with per-pin tri-state GPIO: DATA and DIR banks of NW words each.
// Define GPIO_SYNC_EN to route pin inputs through a 2-flop synchronizer before the read mux.
module axil_gpio
  import axil_gpio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_GPIO     = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  inout  wire  [N_GPIO-1:0]     gpio
);

  localparam int NW       = calc_nw(N_GPIO);
  localparam int PW       = NW * 32;
  localparam int AIW      = ADDR_WIDTH - 2;
  localparam int DIR_BASE = dir_base(NW);

  logic            init_q, init_d;
  logic            aw_held_q, aw_held_d;
  logic [AIW-1:0]  awidx_q, awidx_d;
  logic            w_held_q, w_held_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [N_GPIO-1:0] out_q, out_d;
  logic [N_GPIO-1:0] dir_q, dir_d;

  logic [N_GPIO-1:0] pin_s;
  logic [PW-1:0]     out_pad_s, dir_pad_s, pin_pad_s;
  logic [PW-1:0]     out_wr_s, dir_wr_s;
  logic [31:0]       wmask_s, rd_word_s;
  logic [AIW-1:0]    ar_idx_s;
  logic              aw_hs_s, w_hs_s, ar_hs_s, do_write_s, wr_ok_s, rd_ok_s;
  logic              unused_s;

  assign unused_s = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  for (genvar i = 0; i < N_GPIO; i++) begin : g_pin
    assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

`ifdef GPIO_SYNC_EN
  axil_gpio_sync #(.WIDTH(N_GPIO)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (gpio),
    .q_o (pin_s)
  );
`else
  assign pin_s = gpio;
`endif

  // init_q keeps all ready signals low for the first cycle out of reset
  assign s_axil_awready = init_q & ~aw_held_q & ~bvalid_q;
  assign s_axil_wready  = init_q & ~w_held_q & ~bvalid_q;
  assign s_axil_arready = init_q & ~rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;

  assign aw_hs_s    = s_axil_awvalid & s_axil_awready;
  assign w_hs_s     = s_axil_wvalid & s_axil_wready;
  assign ar_hs_s    = s_axil_arvalid & s_axil_arready;
  assign do_write_s = aw_held_q & w_held_q;
  assign ar_idx_s   = s_axil_araddr[ADDR_WIDTH-1:2];
  assign wr_ok_s    = awidx_q < AIW'(2 * NW);
  assign rd_ok_s    = ar_idx_s < AIW'(2 * NW);
  assign wmask_s    = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

  // zero-pad banks to whole words so bits beyond N_GPIO read as 0
  always_comb begin
    out_pad_s = '0;
    dir_pad_s = '0;
    pin_pad_s = '0;
    out_pad_s[N_GPIO-1:0] = out_q;
    dir_pad_s[N_GPIO-1:0] = dir_q;
    pin_pad_s[N_GPIO-1:0] = pin_s;
  end

  always_comb begin
    out_wr_s  = out_pad_s;
    dir_wr_s  = dir_pad_s;
    rd_word_s = 32'd0;
    for (int k = 0; k < NW; k++) begin
      out_wr_s[k*32 +: 32] = (awidx_q == AIW'(DATA_BASE + k)) ?
          ((out_pad_s[k*32 +: 32] & ~wmask_s) | (wdata_q & wmask_s)) : out_pad_s[k*32 +: 32];
      dir_wr_s[k*32 +: 32] = (awidx_q == AIW'(DIR_BASE + k)) ?
          ((dir_pad_s[k*32 +: 32] & ~wmask_s) | (wdata_q & wmask_s)) : dir_pad_s[k*32 +: 32];
      rd_word_s = rd_word_s
                | ((ar_idx_s == AIW'(DATA_BASE + k)) ? pin_pad_s[k*32 +: 32] : 32'd0)
                | ((ar_idx_s == AIW'(DIR_BASE + k))  ? dir_pad_s[k*32 +: 32] : 32'd0);
    end
  end

  always_comb begin
    init_d    = 1'b1;
    aw_held_d = aw_held_q;
    awidx_d   = awidx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    out_d     = do_write_s ? out_wr_s[N_GPIO-1:0] : out_q;
    dir_d     = do_write_s ? dir_wr_s[N_GPIO-1:0] : dir_q;

    if (aw_hs_s) begin
      aw_held_d = 1'b1;
      awidx_d   = s_axil_awaddr[ADDR_WIDTH-1:2];
    end else if (do_write_s) begin
      aw_held_d = 1'b0;
    end else begin
      aw_held_d = aw_held_q;
    end

    if (w_hs_s) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end else if (do_write_s) begin
      w_held_d = 1'b0;
    end else begin
      w_held_d = w_held_q;
    end

    if (do_write_s) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word_s;
      rresp_d  = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q    <= 1'b0;
      aw_held_q <= 1'b0;
      awidx_q   <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'd0;
      out_q     <= '0;
      dir_q     <= '0;
    end else begin
      init_q    <= init_d;
      aw_held_q <= aw_held_d;
      awidx_q   <= awidx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
    end
  end

endmodule

// File: tb/tb_axil_gpio.sv
// Self-checking bench for axil_gpio (N_GPIO=64): word-level register model plus pin model.
module tb_axil_gpio;

  localparam int N = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] awaddr = 32'd0, araddr = 32'd0, wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [2:0]  awprot = 3'd0, arprot = 3'd0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  wire  [N-1:0] gpio;

  logic [N-1:0] ext_drv = '0;
  logic [31:0]  data_m [2];
  logic [31:0]  dir_m  [2];
  logic [N-1:0] dir_v, data_v;
  logic chk_en = 1'b0;
  int n_total = 0;
  int n_pass  = 0;

  assign dir_v  = {dir_m[1], dir_m[0]};
  assign data_v = {data_m[1], data_m[0]};

  for (genvar i = 0; i < N; i++) begin : g_ext
    assign gpio[i] = dir_v[i] ? 1'bz : ext_drv[i];
  end

  axil_gpio #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .N_GPIO(N)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .gpio(gpio)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Pins: outputs carry the data register, inputs carry whatever the bench drives.
  function automatic logic [63:0] pins_model();
    return (data_v & dir_v) | (ext_drv & ~dir_v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      data_m[i] = 32'd0;
      dir_m[i]  = 32'd0;
    end
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
    logic [29:0] widx;
    widx = addr[31:2];
    if (widx >= 30'd4) return 2'b10;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        if (widx < 30'd2) data_m[widx[0]][8*b +: 8] = d[8*b +: 8];
        else              dir_m[widx[0]][8*b +: 8]  = d[8*b +: 8];
      end
    end
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    logic [29:0] widx;
    logic [63:0] p;
    widx = addr[31:2];
    p = pins_model();
    if (widx < 30'd2) return {2'b00, (widx[0] ? p[63:32] : p[31:0])};
    if (widx < 30'd4) return {2'b00, dir_m[widx[0]]};
    return {2'b10, 32'd0};
  endfunction

  // Called at a negedge; aw_start/w_start are the cycles at which each valid rises.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_start, input int w_start, input int b_delay, output logic [1:0] resp);
    int cyc;
    bit aw_done, w_done, hs_aw, hs_w;
    logic [1:0] exp_resp;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0; resp = 2'bxx;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!aw_done && cyc >= aw_start) begin awaddr = addr; awvalid = 1'b1; end
      if (!w_done && cyc >= w_start) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
      #1;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin wvalid = 1'b0;  w_done = 1'b1; end
      cyc++;
    end
    check("aw_w_accepted", {aw_done, w_done}, 2'b11);
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) return;
    cyc = 0;
    while (!bvalid && cyc < 10) begin @(negedge clk); cyc++; end
    check("bvalid_latency", cyc, 1);
    if (!bvalid) return;
    exp_resp = model_write(addr, data, strb);
    resp = bresp;
    check("bresp", bresp, exp_resp);
    for (int i = 0; i < b_delay; i++) begin
      @(negedge clk);
      check("bvalid_hold", {bvalid, bresp, awready, wready}, {1'b1, exp_resp, 2'b00});
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_done_ready_again", {bvalid, awready, wready}, 3'b011);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_delay, output logic [31:0] d, output logic [1:0] resp);
    logic [33:0] exp;
    int cyc;
    bit hs;
    araddr = addr; arvalid = 1'b1; cyc = 0; hs = 1'b0; exp = '0;
    while (!hs && cyc < 20) begin
      #1;
      hs = arready;
      if (hs) exp = model_read(addr);
      @(negedge clk);
      cyc++;
    end
    arvalid = 1'b0;
    d = rdata; resp = rresp;
    check("ar_accepted", hs, 1'b1);
    if (!hs) return;
    check("rvalid_latency", rvalid, 1'b1);
    check("rdata_model", {rresp, rdata}, exp);
    for (int i = 0; i < r_delay; i++) begin
      @(negedge clk);
      check("r_hold", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, exp});
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("r_done_ready_again", {rvalid, arready}, 2'b01);
  endtask

  task automatic pulse_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
  endtask

  // Pin comparison against the model on every cycle outside reset.
  always @(negedge clk) begin
    #2;
    if (chk_en) check("pins", gpio, pins_model());
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] addr;
    int op;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}, '0);
    rst = 1'b0;
    #1;
    check("ready_low_first_cycle", {awready, wready, arready}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    check("ready_high_after_reset", {awready, wready, arready}, 3'b111);
    chk_en = 1'b1;

    // all pins inputs after reset
    ext_drv = 64'h0F1E_2D3C_4B5A_6978;
    repeat (3) @(negedge clk);
    axi_read(32'h00, 0, d, r); check("reset_pins_z_lo", d, 32'h4B5A_6978);
    axi_read(32'h04, 0, d, r); check("reset_pins_z_hi", d, 32'h0F1E_2D3C);

    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
    axi_write(32'h00, 32'hAAAA_5555, 4'hF, 0, 0, 0, r);
    check("out_aaaa5555", gpio[31:0], 32'hAAAA_5555);
    check("bresp_okay", r, 2'b00);
    axi_write(32'h00, 32'h5555_AAAA, 4'hF, 1, 0, 1, r);
    check("out_5555aaaa", gpio[31:0], 32'h5555_AAAA);

    axi_write(32'h08, 32'h0, 4'hF, 0, 0, 0, r);
    ext_drv[31:0] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    axi_read(32'h00, 0, d, r); check("in_12345678", d, 32'h1234_5678);
    ext_drv[31:0] = 32'h8765_4321;
    repeat (3) @(negedge clk);
    axi_read(32'h00, 2, d, r); check("in_87654321", d, 32'h8765_4321);

    axi_write(32'h0C, 32'h0000_FFFF, 4'hF, 0, 0, 0, r);
    axi_write(32'h04, 32'hDEAD_CAFE, 4'hF, 0, 0, 0, r);
    check("out_cafe", gpio[47:32], 16'hCAFE);
    ext_drv[63:48] = 16'hBEEF;
    repeat (3) @(negedge clk);
    axi_read(32'h04, 0, d, r); check("mixed_beefcafe", d, 32'hBEEF_CAFE);

    pulse_reset();
    axi_write(32'h08, 32'h1122_3344, 4'b0101, 0, 0, 0, r);
    axi_read(32'h08, 0, d, r); check("strb_00220044", d, 32'h0022_0044);

    axi_write(32'h0C, 32'hF0F0_F0F0, 4'hF, 3, 0, 5, r);
    check("w_first_okay", r, 2'b00);
    axi_read(32'h0C, 0, d, r); check("w_first_single", d, 32'hF0F0_F0F0);

    axi_read(32'h10, 0, d, r); check("rd_oob_data", d, 32'd0); check("rd_oob_resp", r, 2'b10);
    axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r); check("wr_oob_resp", r, 2'b10);
    axi_read(32'h08, 0, d, r); check("oob_no_change", d, 32'h0022_0044);

    // reset lands while a captured write is pending
    axi_write(32'h00, 32'h9999_9999, 4'hF, 0, 0, 0, r);
    awaddr = 32'h08; awvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    model_reset();
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ext_drv = 64'hA5A5_3C3C_0123_FEDC;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("abort_no_bvalid", bvalid, 1'b0);
    axi_read(32'h00, 0, d, r); check("abort_pins_z_lo", d, 32'h0123_FEDC);
    axi_read(32'h04, 0, d, r); check("abort_pins_z_hi", d, 32'hA5A5_3C3C);
    axi_read(32'h08, 0, d, r); check("abort_dir0", d, 32'd0);
    axi_read(32'h0C, 0, d, r); check("abort_dir1", d, 32'd0);

    for (int it = 0; it < 160; it++) begin
      op = $urandom_range(0, 9);
      addr = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      if (op < 4) begin
        axi_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), r);
      end else if (op < 8) begin
        axi_read(addr, $urandom_range(0, 3), d, r);
      end else begin
        ext_drv = {$urandom, $urandom};
        repeat (3) @(negedge clk);
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
